out_uart_tx: RTL
================

Name: out_uart_tx

Overview:
- Downstream consumer of one 9-bit output-port word from the output register bank.
- Buffers written bytes in a small FIFO and serialises them as UART 8N1 frames on a single TX line.
- Gives the byter core a serial output channel without CPU-side flow control.
- Reports busy, full and a sticky overflow flag for status readback.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; must be >= 2.
FIFO_DEPTH, 4, byte entries in the FIFO; must be a power of 2.
FIFO_AW, 2, FIFO pointer width; equals log2(FIFO_DEPTH).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
port_in  input  9  output-port word; bit 8 is the write strobe, bits 7:0 are the data byte.
tx  output  1  serial line; idles high.
busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
overflow  output  1  sticky; set when a strobed byte is dropped.

Behaviour:
- Reset, asynchronous: tx=1, busy=0, fifo_full=0, overflow=0, FIFO empty, FSM in IDLE, bit and baud counters 0. Reset mid-frame aborts the frame, forces tx high immediately and flushes the FIFO.
- Push: on every rising edge with port_in[8]=1, port_in[7:0] is written to the FIFO. One byte is pushed per strobed cycle, so a strobe held for N cycles pushes N copies.
- Full FIFO:
  - A push with no pop in the same cycle drops the byte and sets overflow=1. overflow stays set until reset.
  - A push and a pop in the same cycle are both accepted.
- Pop from IDLE: when the FIFO is non-empty, the FSM pops at the next edge, loads the shift register and enters START. tx goes low at that edge. Latency from the push edge to tx falling is 1 cycle.
- FSM states: IDLE -> START -> DATA -> (PARITY) -> STOP.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle: if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity enabled.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter counts 0..7 in DATA.
- FIFO pointers are FIFO_AW+1 bits wide, with the MSB used for full/empty disambiguation. Pointers wrap modulo 2*FIFO_DEPTH.
- Status timing: fifo_full and busy are registered-state decodes and update in the cycle after the edge that changes them. tx is driven directly from a flop.

Optional Feature:
- Macro: OUT_UART_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. tx carries even parity, the XOR of the 8 data bits, for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- When undefined: no PARITY state, no parity logic; the frame is 8N1.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset behaviour: assert reset for 5 cycles -> tx=1, busy=0, fifo_full=0, overflow=0. Hold port_in=9'h0AA (strobe low) for 20 cycles -> tx stays 1.
- Single frame: one-cycle strobe with port_in=9'h155 (byte 0x55) -> tx low 1 cycle later for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles. busy falls 40 cycles after tx falls.
- Back-to-back frames: strobe 0x02 then 0x04 on consecutive cycles -> two contiguous 40-cycle frames with no idle cycle between the stop bit and the second start bit.
- Overflow: strobe 6 consecutive cycles with bytes 0x10..0x15.
  - 0x10 pops on the next edge.
  - fifo_full=1 after 0x14 is pushed.
  - 0x15 is dropped and overflow=1.
  - Exactly 5 frames follow: 0x10..0x14.
- Reset mid-frame: assert reset during DATA bit 3 of byte 0xC0 with 2 bytes queued -> tx=1 immediately and FIFO empty. No further frames until a new strobe.
- Parity (macro defined): send 0x07 -> parity bit 1, frame 44 cycles. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/out_uart_tx.sv
// out_uart_tx
// Serial output channel for the byter core. Bytes strobed in on port_in are
// buffered in a small FIFO and sent on tx as UART frames (start, 8 data bits
// LSB first, optional even parity, stop). Frames run back to back while the
// FIFO has data, so the CPU side needs no flow control.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   port_in    [8] write strobe, [7:0] data byte
//   tx         serial line, idles high, driven from a flop
//   busy       FSM not idle or FIFO non-empty
//   fifo_full  FIFO holds FIFO_DEPTH entries
//   overflow   sticky, a strobed byte was dropped
//
// Build option: define OUT_UART_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1 instead of 8N1).
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] port_in,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

`ifdef OUT_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
`ifdef OUT_UART_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic       empty, full, baud_done, pop, push_ok;
  logic [7:0] rd_data;

  // The pointer MSB distinguishes a full FIFO from an empty one when the
  // low bits match.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    baud_done = (baud_q == BAUD_LAST);
    rd_data   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // still accepted when the FSM is popping.
    pop       = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));
    push_ok   = port_in[8] && (!full || pop);
    wr_ptr_d  = wr_ptr_q + {{FIFO_AW{1'b0}}, push_ok};
    rd_ptr_d  = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    ovf_d     = ovf_q || (port_in[8] && full && !pop);
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= port_in[7:0];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. STOP goes straight to START when more data is queued
  // so consecutive frames have no idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!empty) state_d = S_START;
      S_START:  if (baud_done) state_d = S_DATA;
`ifdef OUT_UART_PARITY_EN
      S_DATA:   if (baud_done && bit_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (baud_done) state_d = S_STOP;
`else
      S_DATA:   if (baud_done && bit_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:   if (baud_done) state_d = empty ? S_IDLE : S_START;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic. tx_d is the value the line takes at the
  // next edge, so every bit change lines up with a state transition.
  always_comb begin
    tx_d     = tx_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = (state_q == S_IDLE || baud_done) ? '0 : baud_q + BAUD_ONE;
`ifdef OUT_UART_PARITY_EN
    parity_d = parity_q;
`endif
    if (pop) begin
      tx_d     = 1'b0;
      shift_d  = rd_data;
      bit_d    = 3'd0;
      baud_d   = '0;
`ifdef OUT_UART_PARITY_EN
      parity_d = ^rd_data;
`endif
    end else if (baud_done) begin
      case (state_q)
        S_START: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
        S_DATA: begin
          if (bit_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
            tx_d = parity_q;
`else
            tx_d = 1'b1;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
`ifdef OUT_UART_PARITY_EN
        S_PARITY: tx_d = 1'b1;
`endif
        default:  tx_d = 1'b1;
      endcase
    end
  end

  // Datapath registers; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
`ifdef OUT_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef OUT_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign fifo_full = full;
  assign overflow  = ovf_q;

endmodule
